// File: rtl/tinyqv_data_arbiter_pkg.sv
// tinyqv_data_arbiter_pkg
// Shared definitions for the TinyQV data-port arbiter: the FSM state
// encoding, the "no transaction" size code, the owner encoding used by the
// last_owner register, and a helper that decides whether a requester is
// asking for the memory port.
`timescale 1ns/1ps

package tinyqv_data_arbiter_pkg;

  // Arbiter FSM state. The encoding is fixed so debug taps and checkers can
  // decode it without referring to the enum.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  // Size code meaning "no access" on read_n / write_n.
  localparam logic [1:0] TXN_NONE = 2'b11;

  // Encoding of the one-bit last_owner register.
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // A requester is asking for the port when either size code is not "none".
  function automatic logic is_requesting(input logic [1:0] read_n,
                                         input logic [1:0] write_n);
    return (read_n != TXN_NONE) || (write_n != TXN_NONE);
  endfunction

endpackage

// File: rtl/tinyqv_data_arbiter.sv
// tinyqv_data_arbiter
// Two-way arbiter sharing the TinyQV memory controller data port between
// requester A (CPU) and requester B (peripheral DMA).
//
// Once a requester owns the port, every m_* output is driven combinationally
// from it and its ready/rdata come straight from the memory controller. A
// burst (continue = 1 on completion) keeps ownership; a non-continued
// completion returns to IDLE for at least one cycle before the next grant.
//
// Build option:
//   TINYQV_ARB_ROUND_ROBIN_EN  defined   -> on a tie in IDLE the requester
//                                           that did not own the port last wins
//                              undefined -> on a tie A always wins
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   a_addr/read_n/write_n/wdata/continue   requester A request
//   a_ready, a_rdata          requester A completion and read data
//   b_*                       requester B, same meaning as A
//   m_addr/read_n/write_n/wdata/continue   memory controller request
//   m_ready, m_rdata          memory controller completion and read data
//   dbg_state                 current FSM state (arb_state_e encoding)
//   dbg_last_owner            last_owner register (OWNER_A / OWNER_B)
//
// Handshake: a requester presents a size code other than 11 and holds all of
// its request fields stable until it sees its ready high at a rising edge;
// ready is high for exactly the cycles in which it owns the port and
// m_ready is high. Nothing here checks that requests stay stable.
`timescale 1ns/1ps

module tinyqv_data_arbiter
  import tinyqv_data_arbiter_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic [ADDR_W-1:0] a_addr,
  input  logic [1:0]        a_write_n,
  input  logic [1:0]        a_read_n,
  input  logic [31:0]       a_wdata,
  input  logic              a_continue,
  output logic              a_ready,
  output logic [31:0]       a_rdata,

  input  logic [ADDR_W-1:0] b_addr,
  input  logic [1:0]        b_write_n,
  input  logic [1:0]        b_read_n,
  input  logic [31:0]       b_wdata,
  input  logic              b_continue,
  output logic              b_ready,
  output logic [31:0]       b_rdata,

  output logic [ADDR_W-1:0] m_addr,
  output logic [1:0]        m_write_n,
  output logic [1:0]        m_read_n,
  output logic [31:0]       m_wdata,
  output logic              m_continue,
  input  logic              m_ready,
  input  logic [31:0]       m_rdata,

  output logic [1:0]        dbg_state,
  output logic              dbg_last_owner
);

  arb_state_e state_q;
  arb_state_e state_d;
  arb_state_e state_eff;
  logic       last_owner_q;
  logic       last_owner_d;

  logic       a_req;
  logic       b_req;
  logic       grant_a;
  logic       grant_b;

  assign a_req = is_requesting(a_read_n, a_write_n);
  assign b_req = is_requesting(b_read_n, b_write_n);

  // Grant decision, only acted on while IDLE.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_req && b_req) begin
`ifdef TINYQV_ARB_ROUND_ROBIN_EN
      // Tie: hand the port to whoever did not have it last.
      if (last_owner_q == OWNER_A) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
`else
      grant_a = 1'b1;
`endif
    end else if (a_req) begin
      grant_a = 1'b1;
    end else if (b_req) begin
      grant_b = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_B;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state logic. A burst (continue high on completion) keeps ownership
  // so a DMA burst is never split by the CPU.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (grant_a) begin
          state_d = OWN_A;
        end else if (grant_b) begin
          state_d = OWN_B;
        end
      end
      OWN_A: begin
        if (m_ready && !a_continue) begin
          state_d      = IDLE;
          last_owner_d = OWNER_A;
        end
      end
      OWN_B: begin
        if (m_ready && !b_continue) begin
          state_d      = IDLE;
          last_owner_d = OWNER_B;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // While reset is low the port is treated as idle at once, so a reset that
  // lands mid-transaction can never leak a completion pulse to the owner.
  assign state_eff = rstn ? state_q : IDLE;

  // Output steering from the current owner.
  always_comb begin
    m_addr     = '0;
    m_read_n   = TXN_NONE;
    m_write_n  = TXN_NONE;
    m_wdata    = '0;
    m_continue = 1'b0;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    case (state_eff)
      OWN_A: begin
        m_addr     = a_addr;
        m_read_n   = a_read_n;
        m_write_n  = a_write_n;
        m_wdata    = a_wdata;
        m_continue = a_continue;
        a_ready    = m_ready;
      end
      OWN_B: begin
        m_addr     = b_addr;
        m_read_n   = b_read_n;
        m_write_n  = b_write_n;
        m_wdata    = b_wdata;
        m_continue = b_continue;
        b_ready    = m_ready;
      end
      default: begin
      end
    endcase
  end

  // Read data is shared; ready tells each requester whether it is theirs.
  assign a_rdata = m_rdata;
  assign b_rdata = m_rdata;

  assign dbg_state      = state_q;
  assign dbg_last_owner = last_owner_q;

endmodule

// File: tb/tb_tinyqv_data_arbiter.sv
// tb_tinyqv_data_arbiter
// Directed bench for tinyqv_data_arbiter. The driver presents requests and
// memory responses cycle by cycle and pushes the output picture it expects
// (tagged with the cycle number) for every cycle in which the memory port
// should be active. The monitor pops an entry whenever the DUT shows any
// activity and compares it; activity with nothing queued, or entries left
// over at the end, are failures.
`timescale 1ns/1ps

module tb_tinyqv_data_arbiter;
  import tinyqv_data_arbiter_pkg::*;

  localparam int ADDR_W = 25;
  localparam int W = 16 + 1 + 1 + 32 + 32 + ADDR_W + 2 + 2 + 32 + 1;

  // Clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // DUT connections
  logic [ADDR_W-1:0] a_addr, b_addr, m_addr;
  logic [1:0]        a_write_n, a_read_n, b_write_n, b_read_n;
  logic [1:0]        m_write_n, m_read_n;
  logic [31:0]       a_wdata, b_wdata, m_wdata;
  logic              a_continue, b_continue, m_continue;
  logic              a_ready, b_ready, m_ready;
  logic [31:0]       a_rdata, b_rdata, m_rdata;
  logic [1:0]        dbg_state;
  logic              dbg_last_owner;

  tinyqv_data_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn),
    .a_addr(a_addr), .a_write_n(a_write_n), .a_read_n(a_read_n),
    .a_wdata(a_wdata), .a_continue(a_continue), .a_ready(a_ready), .a_rdata(a_rdata),
    .b_addr(b_addr), .b_write_n(b_write_n), .b_read_n(b_read_n),
    .b_wdata(b_wdata), .b_continue(b_continue), .b_ready(b_ready), .b_rdata(b_rdata),
    .m_addr(m_addr), .m_write_n(m_write_n), .m_read_n(m_read_n),
    .m_wdata(m_wdata), .m_continue(m_continue), .m_ready(m_ready), .m_rdata(m_rdata),
    .dbg_state(dbg_state), .dbg_last_owner(dbg_last_owner)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic lo_model;

  function automatic logic [W-1:0] pack(input logic [15:0] c, input logic ar, input logic br,
                                        input logic [31:0] ard, input logic [31:0] brd,
                                        input logic [ADDR_W-1:0] addr, input logic [1:0] rn,
                                        input logic [1:0] wn, input logic [31:0] wd,
                                        input logic cont);
    return {c, ar, br, ard, brd, addr, rn, wn, wd, cont};
  endfunction

  // Monitor: any activity on the port or on a ready is an output event.
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    if (m_read_n != TXN_NONE || m_write_n != TXN_NONE || m_continue || a_ready || b_ready) begin
      got = pack(cyc, a_ready, b_ready, a_rdata, b_rdata, m_addr, m_read_n, m_write_n,
                 m_wdata, m_continue);
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output cyc=%0d got=%h required=no activity", cyc, got);
      end else begin
        e = exp_q.pop_front();
        if (got === e) pass_cnt++;
        else $display("FAIL port_output cyc=%0d got=%h required=%h", cyc, got, e);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [ADDR_W-1:0] addr, input logic [1:0] rn, input logic [1:0] wn,
                       input logic [31:0] wd, input logic cont);
    a_addr = addr; a_read_n = rn; a_write_n = wn; a_wdata = wd; a_continue = cont;
  endtask

  task automatic set_b(input logic [ADDR_W-1:0] addr, input logic [1:0] rn, input logic [1:0] wn,
                       input logic [31:0] wd, input logic cont);
    b_addr = addr; b_read_n = rn; b_write_n = wn; b_wdata = wd; b_continue = cont;
  endtask

  task automatic idle_a(); set_a('0, TXN_NONE, TXN_NONE, 32'h0, 1'b0); endtask
  task automatic idle_b(); set_b('0, TXN_NONE, TXN_NONE, 32'h0, 1'b0); endtask

  task automatic mem(input logic rdy, input logic [31:0] rd);
    m_ready = rdy; m_rdata = rd;
  endtask

  // Expect this cycle's port to carry the given owner's request.
  task automatic exp_own(input logic owner);
    if (owner == OWNER_A)
      exp_q.push_back(pack(cyc, m_ready, 1'b0, m_rdata, m_rdata, a_addr, a_read_n, a_write_n,
                           a_wdata, a_continue));
    else
      exp_q.push_back(pack(cyc, 1'b0, m_ready, m_rdata, m_rdata, b_addr, b_read_n, b_write_n,
                           b_wdata, b_continue));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s got=%h required=%h", name, act, req);
  endtask

  task automatic check_idle(input string tag, input logic lo);
    check({tag, "_m_read_n"}, 32'(m_read_n), 32'(TXN_NONE));
    check({tag, "_m_write_n"}, 32'(m_write_n), 32'(TXN_NONE));
    check({tag, "_m_continue"}, 32'(m_continue), 32'd0);
    check({tag, "_a_ready"}, 32'(a_ready), 32'd0);
    check({tag, "_b_ready"}, 32'(b_ready), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    check({tag, "_last_owner"}, 32'(dbg_last_owner), 32'(lo));
  endtask

  // Both request in IDLE; winner completes in one beat, loser follows after
  // one IDLE cycle.
  task automatic run_contest(input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ba);
    logic first;
`ifdef TINYQV_ARB_ROUND_ROBIN_EN
    first = (lo_model == OWNER_A) ? OWNER_B : OWNER_A;
`else
    first = OWNER_A;
`endif
    set_a(aa, 2'b01, TXN_NONE, 32'h0, 1'b0);
    set_b(ba, 2'b10, TXN_NONE, 32'h0, 1'b0);
    mem(1'b0, 32'h0);
    tick();
    mem(1'b1, 32'hC0DE_0000 | 32'(aa));
    exp_own(first);
    tick();
    if (first == OWNER_A) idle_a(); else idle_b();
    mem(1'b0, 32'h0);
    tick();
    mem(1'b1, 32'hFACE_0000 | 32'(ba));
    exp_own(~first);
    tick();
    idle_a(); idle_b();
    mem(1'b0, 32'h0);
    lo_model = ~first;
    tick();
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    idle_a(); idle_b();
    mem(1'b0, 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    lo_model = OWNER_B;
    check_idle("reset", OWNER_B);

    // A reads a word at 0x100; one wait state, then DEADBEEF.
    set_a(25'h000100, 2'b10, TXN_NONE, 32'h0, 1'b0);
    tick();
    mem(1'b0, 32'h0);
    exp_own(OWNER_A);
    tick();
    mem(1'b1, 32'hDEADBEEF);
    exp_own(OWNER_A);
    tick();
    idle_a();
    mem(1'b0, 32'h0);
    lo_model = OWNER_A;
    tick();

    // Simultaneous requests, twice.
    run_contest(25'h000200, 25'h000300);
    run_contest(25'h000210, 25'h000310);

    // B 3-word burst while A waits.
    set_b(25'h000400, 2'b10, TXN_NONE, 32'h0, 1'b1);
    mem(1'b0, 32'h0);
    tick();
    set_a(25'h000500, 2'b10, TXN_NONE, 32'h0, 1'b0);
    mem(1'b1, 32'h1111_0001);
    exp_own(OWNER_B);
    tick();
    set_b(25'h000404, 2'b10, TXN_NONE, 32'h0, 1'b1);
    mem(1'b0, 32'h0);
    exp_own(OWNER_B);
    tick();
    mem(1'b1, 32'h1111_0002);
    exp_own(OWNER_B);
    tick();
    set_b(25'h000408, 2'b10, TXN_NONE, 32'h0, 1'b0);
    mem(1'b1, 32'h1111_0003);
    exp_own(OWNER_B);
    tick();
    idle_b();
    mem(1'b0, 32'h0);
    tick();
    mem(1'b1, 32'h2222_0001);
    exp_own(OWNER_A);
    tick();
    idle_a();
    mem(1'b0, 32'h0);
    lo_model = OWNER_A;
    tick();

    // A byte write while B's read is pending.
    set_a(25'h000123, TXN_NONE, 2'b00, 32'h12345678, 1'b0);
    tick();
    set_b(25'h000600, 2'b10, TXN_NONE, 32'h0, 1'b0);
    exp_own(OWNER_A);
    tick();
    mem(1'b1, 32'h3333_0001);
    exp_own(OWNER_A);
    tick();
    idle_a();
    mem(1'b0, 32'h0);
    lo_model = OWNER_A;
    tick();
    mem(1'b1, 32'h4444_0001);
    exp_own(OWNER_B);
    tick();
    idle_b();
    mem(1'b0, 32'h0);
    lo_model = OWNER_B;
    tick();

    // Reset while B owns the port and memory has not finished; memory
    // raises m_ready during the reset cycle, which must not reach B.
    set_b(25'h000700, 2'b10, TXN_NONE, 32'h0, 1'b0);
    tick();
    exp_own(OWNER_B);
    tick();
    rstn = 1'b0;
    mem(1'b1, 32'hBAD0_0001);
    tick();
    rstn = 1'b1;
    idle_b();
    mem(1'b0, 32'h0);
    lo_model = OWNER_B;
    check_idle("mid_reset", OWNER_B);
    tick();

    // After reset A must win the first tie in either build.
    run_contest(25'h000800, 25'h000900);

    repeat (3) tick();
    chk_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL missing_outputs got=%0d leftover required=0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tinyqv_data_arbiter.md
TINYQV_DATA_ARBITER -- requirements
Module: tinyqv_data_arbiter

Interface
REQ-001 Parameter ADDR_W, default 25, sets the data address width for both requesters and the memory port.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 a_addr  input  ADDR_W  requester A (CPU) address.
REQ-005 a_write_n, a_read_n  input  2 each  requester A size code: 11 none, 00 byte, 01 half, 10 word.
REQ-006 a_wdata  input  32  requester A write data; a_continue  input  1  another access at the next address follows immediately.
REQ-007 a_ready  output  1  requester A transaction complete; a_rdata  output  32  requester A read data.
REQ-008 b_addr, b_write_n, b_read_n, b_wdata, b_continue, b_ready, b_rdata: requester B (peripheral DMA), same widths and meanings as A.
REQ-009 m_addr  output  ADDR_W, m_write_n  output  2, m_read_n  output  2, m_wdata  output  32, m_continue  output  1: drive the memory controller data port.
REQ-010 m_ready  input  1, m_rdata  input  32: memory controller completion and read data.

Function
REQ-011 A requester is "requesting" when its read_n or write_n differs from 11.
REQ-012 FSM states: IDLE, OWN_A, OWN_B; a one-bit last_owner register records the most recent grant.
REQ-013 IDLE: m_read_n = m_write_n = 11, m_continue = 0, and both readys are 0.
REQ-014 IDLE -> OWN_x on the clock edge following a cycle in which x wins arbitration; the memory port sees the request one cycle after it is first presented.
REQ-015 OWN_x: all m_* outputs are combinationally driven from requester x; x_ready = m_ready; x_rdata = m_rdata.
REQ-016 While OWN_x, the other requester's ready is 0, and its inputs are ignored.
REQ-017 OWN_x with m_ready = 1 and x_continue = 1: stay in OWN_x. Burst continuation is never pre-empted.
REQ-018 OWN_x with m_ready = 1 and x_continue = 0: go to IDLE next cycle; last_owner <= x.
REQ-019 OWN_x with m_ready = 0: hold state. Requesters hold their request stable until ready; the arbiter does not check this.
REQ-020 Both readys are 0 in any cycle where m_ready = 0.
REQ-021 a_rdata and b_rdata pass m_rdata through unchanged and unregistered in every state.
REQ-022 A single requester in IDLE always wins, regardless of last_owner.
REQ-023 The minimum gap between consecutive non-continued grants is one IDLE cycle.

Reset
REQ-024 rstn low for one edge forces IDLE and last_owner = B, so A wins the first contest.
REQ-025 After reset, all m_read_n/m_write_n = 11, m_continue = 0, and both readys = 0.
REQ-026 A reset asserted mid-transaction abandons ownership immediately, with no completion signalled to either requester.

Configuration
REQ-027 Macro TINYQV_ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, the requester that is not last_owner wins.
REQ-028 Macro TINYQV_ARB_ROUND_ROBIN_EN undefined: on simultaneous requests in IDLE, A always wins. The last_owner register is then still present but unused for arbitration.

Structure
REQ-029 A shared package holds the FSM state encoding (IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2) and the size-code constant TXN_NONE = 2'b11.
REQ-030 The block is a single module with no sub-modules; the grant decision stays inline combinational logic.

Verification
REQ-031 Reset, then A reads a word at 0x000100 (a_read_n = 10) -> m_read_n = 10 one cycle later; a_ready pulses with m_ready; m_rdata 0xDEADBEEF appears on a_rdata.
REQ-032 A and B request in the same IDLE cycle, round-robin on, after an A transaction -> B granted; B completes; A is then granted after one IDLE cycle.
REQ-033 Same stimulus as REQ-032 with the macro undefined -> A is granted on every contest; B is granted only when A is idle.
REQ-034 B 3-word burst with b_continue = 1 for the first two words, while A requests throughout -> m_* stays on B across all three m_ready pulses, a_ready stays 0, and A is granted after the burst.
REQ-035 A write with a_wdata = 0x12345678 and a_write_n = 00, while B's read is pending -> m_wdata = 0x12345678 and m_write_n = 00; b_ready stays 0 until B is granted.
REQ-036 rstn asserted while OWN_B with m_ready = 0 -> next cycle IDLE, all m_read_n/m_write_n = 11, and no ready pulse on either requester.
